// File: rtl/jpeg_bitstream_unstuffer.sv
// JPEG entropy-coded segment unstuffer: removes 0xFF00 stuffing, skips fill bytes,
// detects markers and exposes a left-aligned bit window. Optional JPEG_UNSTUFF_RST_EN handles RSTn.
module jpeg_bitstream_unstuffer #(
  parameter int BUF_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] bits_out,
  output logic [6:0]  bits_avail,
  input  logic        consume_en,
  input  logic [4:0]  consume_len,
  output logic        consume_err,
  output logic        marker_valid,
  output logic [7:0]  marker_code,
  input  logic        marker_ack,
  output logic        rst_pulse,
  output logic [2:0]  rst_idx
);

  typedef enum logic [1:0] {
    DATA        = 2'd0,
    FF_SEEN     = 2'd1,
    MARKER_HOLD = 2'd2
  } state_t;

  localparam logic [6:0] FILL_LIMIT = 7'(BUF_W - 8);

  state_t           state_reg, state_next;
  logic [BUF_W-1:0] buf_reg, buf_next;
  logic [6:0]       avail_reg, avail_next;
  logic             marker_valid_reg, marker_valid_next;
  logic [7:0]       marker_code_reg, marker_code_next;
  logic             consume_err_reg, consume_err_next;

  logic             accept;
  logic             consume_ok;
  logic [6:0]       kept_cnt;
  logic [BUF_W-1:0] kept_buf;
  logic             append_en;
  logic [7:0]       append_byte;
  logic [BUF_W-1:0] append_word;
  logic             clear_buf;

`ifdef JPEG_UNSTUFF_RST_EN
  logic             rst_pulse_reg, rst_pulse_next;
  logic [2:0]       rst_idx_reg, rst_idx_next;
`endif

  // Readiness depends only on registered state so the producer sees no comb path from its own valid.
  assign in_ready = (state_reg != MARKER_HOLD) && (avail_reg <= FILL_LIMIT);
  assign accept   = in_valid && in_ready;

  assign consume_ok = consume_en && (consume_len != 5'd0) && (consume_len <= 5'd16) &&
                      ({2'b00, consume_len} <= avail_reg);
  assign kept_cnt   = consume_ok ? (avail_reg - {2'b00, consume_len}) : avail_reg;
  assign kept_buf   = consume_ok ? (buf_reg << consume_len) : buf_reg;

  // New byte lands directly after the bits that survive this cycle's consume.
  assign append_word = {append_byte, {(BUF_W-8){1'b0}}} >> kept_cnt;

  always_comb begin
    state_next        = state_reg;
    marker_valid_next = marker_valid_reg;
    marker_code_next  = marker_code_reg;
    append_en         = 1'b0;
    append_byte       = in_data;
    clear_buf         = 1'b0;
`ifdef JPEG_UNSTUFF_RST_EN
    rst_pulse_next    = 1'b0;
    rst_idx_next      = rst_idx_reg;
`endif
    case (state_reg)
      DATA: begin
        if (accept) begin
          if (in_data == 8'hFF) state_next = FF_SEEN;
          else                  append_en  = 1'b1;
        end
      end
      FF_SEEN: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            append_en   = 1'b1;
            append_byte = 8'hFF;
            state_next  = DATA;
          end else if (in_data == 8'hFF) begin
            state_next = FF_SEEN;
          end
`ifdef JPEG_UNSTUFF_RST_EN
          else if (in_data[7:3] == 5'b11010) begin
            clear_buf      = 1'b1;
            rst_pulse_next = 1'b1;
            rst_idx_next   = in_data[2:0];
            state_next     = DATA;
          end
`endif
          else begin
            marker_valid_next = 1'b1;
            marker_code_next  = in_data;
            state_next        = MARKER_HOLD;
          end
        end
      end
      MARKER_HOLD: begin
        if (marker_ack) begin
          marker_valid_next = 1'b0;
          clear_buf         = 1'b1;
          state_next        = DATA;
        end
      end
      default: state_next = DATA;
    endcase
  end

  always_comb begin
    buf_next         = kept_buf | (append_en ? append_word : '0);
    avail_next       = kept_cnt + (append_en ? 7'd8 : 7'd0);
    consume_err_next = consume_en && !consume_ok;
    if (clear_buf) begin
      buf_next   = '0;
      avail_next = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= DATA;
      buf_reg          <= '0;
      avail_reg        <= 7'd0;
      marker_valid_reg <= 1'b0;
      marker_code_reg  <= 8'h00;
      consume_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      buf_reg          <= buf_next;
      avail_reg        <= avail_next;
      marker_valid_reg <= marker_valid_next;
      marker_code_reg  <= marker_code_next;
      consume_err_reg  <= consume_err_next;
    end
  end

`ifdef JPEG_UNSTUFF_RST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_pulse_reg <= 1'b0;
      rst_idx_reg   <= 3'd0;
    end else begin
      rst_pulse_reg <= rst_pulse_next;
      rst_idx_reg   <= rst_idx_next;
    end
  end
  assign rst_pulse = rst_pulse_reg;
  assign rst_idx   = rst_idx_reg;
`else
  assign rst_pulse = 1'b0;
  assign rst_idx   = 3'd0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bits_out
      assign bits_out[gi] = buf_reg[BUF_W-16+gi];
    end
  endgenerate

  assign bits_avail   = avail_reg;
  assign consume_err  = consume_err_reg;
  assign marker_valid = marker_valid_reg;
  assign marker_code  = marker_code_reg;

endmodule
